// File: rtl/timer_arbiter_pkg.sv
// Shared types and default sizing for the timer arbiter: FSM state encoding
// and the default requester count / counter width.
package timer_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  localparam int NREQ_DEFAULT = 4;
  localparam int N_DEFAULT    = 8;

endpackage

// File: rtl/timer_arbiter_pick.sv
// Combinational winner select: round-robin from PTR when TIMER_ARBITER_RR_EN
// is defined, otherwise fixed priority (lowest index wins, PTR ignored).
module timer_arbiter_pick
  import timer_arbiter_pkg::*;
#(
  parameter int nreq = NREQ_DEFAULT,
  parameter int pw   = $clog2(nreq)
) (
  input  logic [nreq-1:0] REQ,
  input  logic [pw-1:0]   PTR,
  output logic [nreq-1:0] WIN
);

  logic found;

`ifdef TIMER_ARBITER_RR_EN
  int idx;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    WIN   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < nreq; i++) begin
      idx = (int'(PTR) + i) % nreq;
      if (!found && REQ[idx]) begin
        WIN[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^PTR;

  always_comb begin
    WIN   = '0;
    found = 1'b0;
    for (int i = 0; i < nreq; i++) begin
      if (!found && REQ[i]) begin
        WIN[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/timer_arbiter.sv
// Shared loadable down-counter granted to one of nreq requesters at a time.
// Define TIMER_ARBITER_RR_EN for round-robin arbitration; default is fixed priority.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int nreq = NREQ_DEFAULT,
  parameter int n    = N_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [nreq-1:0]   REQ,
  input  logic [nreq*n-1:0] LOAD,
  output logic [nreq-1:0]   GNT,
  output logic [nreq-1:0]   DONE,
  output logic              BUSY,
  output logic [n-1:0]      COUNT
);

  localparam int PW = $clog2(nreq);

  state_t          state, state_nxt;
  logic [nreq-1:0] win;
  logic [n-1:0]    load_sel;
  logic [PW-1:0]   ptr;
  logic            abort;

  // The granted requester withdrawing mid-count cancels the operation.
  assign abort = (state == RUN) && ((REQ & GNT) == '0);

  timer_arbiter_pick #(.nreq(nreq), .pw(PW)) u_pick (
    .REQ (REQ),
    .PTR (ptr),
    .WIN (win)
  );

  always_comb begin
    load_sel = '0;
    for (int i = 0; i < nreq; i++) begin
      if (win[i]) load_sel = LOAD[i*n +: n];
    end
  end

`ifdef TIMER_ARBITER_RR_EN
  logic [PW-1:0] gnt_idx;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < nreq; i++) begin
      if (GNT[i]) gnt_idx = PW'(i);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr <= '0;
    end else if (state == FIN || abort) begin
      ptr <= (gnt_idx == PW'(nreq - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end
`else
  assign ptr = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|REQ) state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (COUNT == '0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state != IDLE);
    DONE = (state == FIN) ? GNT : '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      GNT   <= '0;
      COUNT <= '0;
    end else begin
      case (state)
        IDLE: begin
          // win and load_sel are zero when nothing is requesting.
          GNT   <= win;
          COUNT <= load_sel;
        end
        RUN: begin
          if (abort) begin
            GNT   <= '0;
            COUNT <= '0;
          end else if (COUNT != '0) begin
            COUNT <= COUNT - n'(1);
          end
        end
        default: begin
          GNT   <= '0;
          COUNT <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Randomized self-checking bench for timer_arbiter against a transaction-level model.
module tb_timer_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 8;

  logic              CLK;
  logic              RST_N;
  logic [NREQ-1:0]   REQ;
  logic [NREQ*N-1:0] LOAD;
  logic [NREQ-1:0]   GNT;
  logic [NREQ-1:0]   DONE;
  logic              BUSY;
  logic [N-1:0]      COUNT;

  int vectors     = 0;
  int miscompares = 0;
  int ptr_m       = 0;

  timer_arbiter #(.nreq(NREQ), .n(N)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ   (REQ),
    .LOAD  (LOAD),
    .GNT   (GNT),
    .DONE  (DONE),
    .BUSY  (BUSY),
    .COUNT (COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected run to complete");
    $fatal(1);
  end

  // Reference winner: round-robin scans upward from the pointer, else lowest index.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
`ifdef TIMER_ARBITER_RR_EN
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
`else
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int g);
    logic [NREQ-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Entered in IDLE just after an edge with REQ/LOAD driven; follows one grant to its end.
  task automatic run_grant(input int g, input int L, input int abort_at, input bit drop_fin,
                           input bit chg_load, input logic [N-1:0] new_load);
    logic [NREQ-1:0] eg;
    eg = oh(g);
    tick();
    vectors++; if (GNT !== eg) begin miscompares++; $display("FAIL grant: got %b expected %b", GNT, eg); end
    vectors++; if (COUNT !== N'(L)) begin miscompares++; $display("FAIL load: got %0d expected %0d", COUNT, L); end
    vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("FAIL busy_grant: got %b expected 1", BUSY); end
    vectors++; if (DONE !== '0) begin miscompares++; $display("FAIL done_grant: got %b expected 0000", DONE); end
    if (chg_load) LOAD[g*N +: N] = new_load;
    for (int k = 0; k <= L; k++) begin
      if (k == abort_at) begin
        REQ[g] = 1'b0;
        tick();
        vectors++; if (GNT !== '0) begin miscompares++; $display("FAIL abort_gnt: got %b expected 0000", GNT); end
        vectors++; if (COUNT !== '0) begin miscompares++; $display("FAIL abort_count: got %0d expected 0", COUNT); end
        vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", BUSY); end
        vectors++; if (DONE !== '0) begin miscompares++; $display("FAIL abort_done: got %b expected 0000", DONE); end
        ptr_m = (g + 1) % NREQ;
        return;
      end
      tick();
      if (k < L) begin
        vectors++; if (COUNT !== N'(L - k - 1)) begin miscompares++; $display("FAIL count: got %0d expected %0d", COUNT, L - k - 1); end
        vectors++; if (GNT !== eg) begin miscompares++; $display("FAIL gnt_hold: got %b expected %b", GNT, eg); end
        vectors++; if (DONE !== '0) begin miscompares++; $display("FAIL early_done: got %b expected 0000", DONE); end
      end
    end
    vectors++; if (DONE !== eg) begin miscompares++; $display("FAIL done_pulse: got %b expected %b", DONE, eg); end
    vectors++; if (GNT !== eg) begin miscompares++; $display("FAIL fin_gnt: got %b expected %b", GNT, eg); end
    vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("FAIL fin_busy: got %b expected 1", BUSY); end
    if (drop_fin) begin
      REQ[g] = 1'b0;
      #1;
      vectors++; if (DONE !== eg) begin miscompares++; $display("FAIL fin_drop_done: got %b expected %b", DONE, eg); end
    end
    tick();
    vectors++; if (GNT !== '0) begin miscompares++; $display("FAIL idle_gnt: got %b expected 0000", GNT); end
    vectors++; if (DONE !== '0) begin miscompares++; $display("FAIL idle_done: got %b expected 0000", DONE); end
    vectors++; if (COUNT !== '0) begin miscompares++; $display("FAIL idle_count: got %0d expected 0", COUNT); end
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", BUSY); end
    ptr_m = (g + 1) % NREQ;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    REQ   = '0;
    LOAD  = '0;
    tick();
    tick();
    vectors++; if (GNT !== '0) begin miscompares++; $display("FAIL reset_gnt: got %b expected 0000", GNT); end
    vectors++; if (DONE !== '0) begin miscompares++; $display("FAIL reset_done: got %b expected 0000", DONE); end
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    vectors++; if (COUNT !== '0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", COUNT); end
    RST_N = 1'b1;
    ptr_m = 0;
  endtask

  task automatic test_idle();
    REQ = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (GNT !== '0 || DONE !== '0 || COUNT !== '0 || BUSY !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_hold: got gnt=%b done=%b count=%0d busy=%b expected all zero", GNT, DONE, COUNT, BUSY);
      end
    end
  endtask

  task automatic test_basic();
    REQ = 4'b0001;
    LOAD = '0;
    LOAD[0*N +: N] = 8'd5;
    run_grant(pick(REQ, ptr_m), 5, -1, 1'b0, 1'b0, '0);
    REQ = '0;
  endtask

  task automatic test_zero_load();
    REQ = 4'b0100;
    LOAD[2*N +: N] = 8'd0;
    run_grant(pick(REQ, ptr_m), 0, -1, 1'b0, 1'b0, '0);
    REQ = '0;
  endtask

  task automatic test_abort();
    REQ = 4'b0010;
    LOAD[1*N +: N] = 8'd10;
    // Count is 4 when k reaches 6.
    run_grant(1, 10, 6, 1'b0, 1'b0, '0);
    REQ = '0;
    tick();
    REQ = 4'b1111;
    for (int i = 0; i < NREQ; i++) LOAD[i*N +: N] = 8'd1;
    run_grant(pick(REQ, ptr_m), 1, -1, 1'b0, 1'b0, '0);
    REQ = '0;
  endtask

  task automatic test_round_robin();
    int exp_order[5];
`ifdef TIMER_ARBITER_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    ptr_m = 0;
    for (int i = 0; i < NREQ; i++) LOAD[i*N +: N] = N'($urandom_range(0, 3));
    REQ = 4'b1111;
    for (int i = 0; i < 5; i++)
      run_grant(exp_order[i], int'(LOAD[exp_order[i]*N +: N]), -1, 1'b0, 1'b0, '0);
    REQ = '0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    REQ = 4'b0001;
    LOAD[0*N +: N] = 8'd9;
    tick();
    tick();
    tick();
    vectors++; if (COUNT !== 8'd7) begin miscompares++; $display("FAIL pre_reset_count: got %0d expected 7", COUNT); end
    #1 RST_N = 1'b0;
    #1;
    vectors++; if (GNT !== '0) begin miscompares++; $display("FAIL async_gnt: got %b expected 0000", GNT); end
    vectors++; if (COUNT !== '0) begin miscompares++; $display("FAIL async_count: got %0d expected 0", COUNT); end
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL async_busy: got %b expected 0", BUSY); end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (DONE !== '0) begin miscompares++; $display("FAIL reset_no_done: got %b expected 0000", DONE); end
    end
    REQ = 4'b1000;
    LOAD[3*N +: N] = 8'd2;
    RST_N = 1'b1;
    ptr_m = 0;
    run_grant(pick(REQ, ptr_m), 2, -1, 1'b0, 1'b0, '0);
    REQ = '0;
  endtask

  task automatic test_load_change();
    REQ = 4'b0001;
    LOAD[0*N +: N] = 8'd3;
    run_grant(0, 3, -1, 1'b0, 1'b1, 8'd200);
    REQ = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] r;
    int g, L, ab;
    bit drop;
    for (int it = 0; it < 40; it++) begin
      r = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) LOAD[i*N +: N] = N'($urandom_range(0, 12));
      REQ  = r;
      g    = pick(r, ptr_m);
      L    = int'(LOAD[g*N +: N]);
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, L)) : -1;
      drop = 1'($urandom_range(0, 1));
      run_grant(g, L, ab, drop, 1'b0, '0);
      REQ = '0;
      tick();
      vectors++; if (GNT !== '0 || BUSY !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_idle: got gnt=%b busy=%b expected 0000/0", GNT, BUSY);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_zero_load();
    test_abort();
    test_round_robin();
    test_reset_mid_run();
    test_load_change();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
